onewire_master: RTL and testbench
=================================

Name: onewire_master

Overview:
- Single-byte 1-Wire bus master. Issues a reset pulse, detects the slave presence pulse, then runs eight read time slots and assembles the returned byte, LSB first.
- Sits between system logic and the shared open-drain data line.
- Drives the line low only while `en` = 1. Otherwise it releases the line, which the slave or the pull-up then owns.

Parameters:
- RESET_CYCLES, 48, clocks the line is held low for a bus reset. Must be > 40.
- PRES_SAMPLE, 4, clocks after reset release at which presence is sampled.
- PRES_CYCLES, 48, total length of the presence window after reset release.
- SLOT_LOW, 2, clocks the line is held low to open a read slot. Must be 1..39.
- SAMPLE_DELAY, 4, clocks after slot release at which data is sampled. Must be >= 2.
- SLOT_CYCLES, 16, total released portion of a slot including recovery. Must be > SAMPLE_DELAY.
- All parameters < 1024.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  out  1  line-drive enable; 1 = master pulls the line low, 0 = line released.
- port  inout  1  1-Wire data line; driven 0 when `en` = 1, high-Z otherwise.
- master_mem  out  8  received byte.
- master_init  out  1  presence detected during the current session.
- master_cnt  out  10  current phase cycle counter.
- cycl  out  1  high while a read slot is in progress (low and released portions).
- rcvd  out  1  byte complete.
- master_idata  out  1  most recently sampled data bit.

Behaviour:
- Reset (`reset` = 0, asynchronous): outputs take these values.
  - `en` = 0, `master_mem` = 0, `master_init` = 0, `master_cnt` = 0, `cycl` = 0, `rcvd` = 0, `master_idata` = 0.
  - Internal bit index = 0; FSM = RST_LOW.
  - Asserting reset mid-operation aborts immediately with the same values.
- FSM states: RST_LOW, PRES, SLOT_LOW, SLOT_REL, DONE.
- `master_cnt` is cleared on every state entry and increments by 1 each clock within a state. It is 10 bits and never wraps, given the parameter limits.
- RST_LOW:
  - `en` = 1 for RESET_CYCLES clocks, then go to PRES.
  - The first rising clock after reset release is cycle 0 of RST_LOW.
- PRES:
  - `en` = 0.
  - At `master_cnt` == PRES_SAMPLE, sample `port`. Exactly 0 sets `master_init` = 1; 1, X or Z counts as absent.
  - At `master_cnt` == PRES_CYCLES-1: if `master_init` = 1, go to SLOT_LOW; else return to RST_LOW and retry indefinitely.
- SLOT_LOW:
  - `en` = 1 and `cycl` = 1 for SLOT_LOW clocks, then go to SLOT_REL.
- SLOT_REL:
  - `en` = 0 and `cycl` = 1.
  - At `master_cnt` == SAMPLE_DELAY, sample `port` (0 if exactly 0, else 1) into `master_idata` and into `master_mem[bit index]`; bit index increments.
  - At `master_cnt` == SLOT_CYCLES-1, `cycl` = 0. If 8 bits are done, go to DONE; else go to SLOT_LOW.
- DONE:
  - `en` = 0 and `rcvd` = 1 (level).
  - `master_mem` is held stable. Remains in DONE until reset.
- Bit order: the first slot fills `master_mem[0]`, the eighth fills `master_mem[7]`.
- `master_mem` bits not yet received keep their reset value 0. Partial results are visible as received.
- Slot length is fixed regardless of data value.
- `rcvd` and `master_init` are never cleared except by reset.

Test Plan:
- Release reset with a presence-capable slave sending byte 0xAA:
  - `en` is high for exactly 48 clocks, then low; `master_init` = 1 during PRES.
  - Eight slots follow, each with `en` high for 2 clocks.
  - `rcvd` = 1 and `master_mem` = 0xAA. `master_idata` follows bits 0,1,0,1,0,1,0,1.
- Slave byte 0x00 and 0xFF (separate runs) -> `master_mem` = 0x00 / 0xFF, `rcvd` = 1 after the 8th slot.
- No slave (line pulled high, never 0 in PRES) -> `master_init` stays 0, `rcvd` stays 0, `en` repeats a 48-clock low pulse every 96 clocks.
- Assert reset during the 4th slot -> all outputs return to 0 asynchronously. After release, the sequence restarts with a 48-clock reset pulse and the byte is received correctly.
- Check `cycl` is 1 only during slots. Check `master_cnt` restarts at 0 on each state entry. Check `port` is high-Z whenever `en` = 0 and 0 whenever `en` = 1.

Source files
------------

// File: rtl/onewire_master.sv
// onewire_master: single-byte 1-Wire bus master.
// Issues a bus reset pulse and checks for a presence pulse. If a slave answers,
// it runs eight read slots and assembles the returned byte, LSB first.
// The bus is open-drain. This block only ever pulls the line low (en = 1) or releases it.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   en           1 = master pulls the line low, 0 = line released
//   port         1-Wire data line (0 when en, high-Z otherwise)
//   master_mem   received byte (bits fill in as they arrive)
//   master_init  presence seen this session (sticky until reset)
//   master_cnt   cycle counter within the current FSM state
//   cycl         read slot in progress
//   rcvd         all eight bits received (sticky until reset)
//   master_idata most recently sampled data bit
module onewire_master #(
  parameter int RESET_CYCLES = 48,
  parameter int PRES_SAMPLE  = 4,
  parameter int PRES_CYCLES  = 48,
  parameter int SLOT_LOW     = 2,
  parameter int SAMPLE_DELAY = 4,
  parameter int SLOT_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic       en,
  inout  wire        port,
  output logic [7:0] master_mem,
  output logic       master_init,
  output logic [9:0] master_cnt,
  output logic       cycl,
  output logic       rcvd,
  output logic       master_idata
);

  localparam logic [9:0] RST_LAST  = 10'(RESET_CYCLES - 1);
  localparam logic [9:0] PRES_SMP  = 10'(PRES_SAMPLE);
  localparam logic [9:0] PRES_LAST = 10'(PRES_CYCLES - 1);
  localparam logic [9:0] SLOW_LAST = 10'(SLOT_LOW - 1);
  localparam logic [9:0] DATA_SMP  = 10'(SAMPLE_DELAY);
  localparam logic [9:0] SLOT_LAST = 10'(SLOT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RST_LOW, ST_PRES, ST_SLOT_LOW, ST_SLOT_REL, ST_DONE
  } state_t;

  state_t     state, state_nxt;
  // The reset state is RST_LOW. The line must still stay released during reset.
  // 'started' holds everything idle until the first clock after reset release.
  // That clock then becomes cycle 0 of the bus reset pulse.
  logic       started;
  logic [3:0] bit_cnt;

  assign port = en ? 1'b0 : 1'bz;

  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    cycl      = 1'b0;
    rcvd      = 1'b0;
    if (started) begin
      unique case (state)
        ST_RST_LOW: begin
          en = 1'b1;
          if (master_cnt == RST_LAST) state_nxt = ST_PRES;
        end
        ST_PRES: begin
          if (master_cnt == PRES_LAST)
            state_nxt = master_init ? ST_SLOT_LOW : ST_RST_LOW;
        end
        ST_SLOT_LOW: begin
          en   = 1'b1;
          cycl = 1'b1;
          if (master_cnt == SLOW_LAST) state_nxt = ST_SLOT_REL;
        end
        ST_SLOT_REL: begin
          // cycl drops in the last recovery clock to mark the slot boundary
          cycl = (master_cnt != SLOT_LAST);
          if (master_cnt == SLOT_LAST)
            state_nxt = (bit_cnt == 4'd8) ? ST_DONE : ST_SLOT_LOW;
        end
        ST_DONE: rcvd = 1'b1;
        default: state_nxt = ST_RST_LOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RST_LOW;
      started      <= 1'b0;
      bit_cnt      <= 4'd0;
      master_cnt   <= 10'd0;
      master_mem   <= 8'd0;
      master_init  <= 1'b0;
      master_idata <= 1'b0;
    end else begin
      started <= 1'b1;
      if (started) begin
        state <= state_nxt;
        // Every transition changes state, so a state change is a state entry.
        // Saturation only matters in DONE, which never exits on its own.
        if (state_nxt != state)       master_cnt <= 10'd0;
        else if (master_cnt != '1)    master_cnt <= master_cnt + 10'd1;

        // Only an exact 0 counts as presence. X/Z/1 all read as absent.
        if (state == ST_PRES && master_cnt == PRES_SMP && port == 1'b0)
          master_init <= 1'b1;

        if (state == ST_SLOT_REL && master_cnt == DATA_SMP) begin
          if (port == 1'b0) begin
            master_idata             <= 1'b0;
            master_mem[bit_cnt[2:0]] <= 1'b0;
          end else begin
            master_idata             <= 1'b1;
            master_mem[bit_cnt[2:0]] <= 1'b1;
          end
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_onewire_master.sv
// Testbench for onewire_master.
// A behavioural slave watches the bus. After a long low it answers with a presence pulse.
// After a short low it pulls the line low for a 0 bit.
// A per-cycle timing model gives the expected value of every output on every clock,
// measured from reset release.
module tb_onewire_master;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en;
  wire        port;
  logic [7:0] master_mem;
  logic       master_init;
  logic [9:0] master_cnt;
  logic       cycl, rcvd, master_idata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  onewire_master dut (
    .clk(clk), .reset(reset), .en(en), .port(port),
    .master_mem(master_mem), .master_init(master_init), .master_cnt(master_cnt),
    .cycl(cycl), .rcvd(rcvd), .master_idata(master_idata)
  );

  // Slave side of the open-drain bus
  logic       slave_low;
  logic       slv_present = 1'b1;
  logic [7:0] slv_byte = 8'h00;
  int         low_cnt, hold;
  logic [2:0] sidx;

  pullup (port);
  assign port = slave_low ? 1'b0 : 1'bz;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      low_cnt <= 0; hold <= 0; slave_low <= 1'b0; sidx <= 3'd0;
    end else if (en) begin
      low_cnt <= low_cnt + 1;
    end else begin
      low_cnt <= 0;
      if (low_cnt >= 40) begin
        sidx <= 3'd0;
        if (slv_present) begin slave_low <= 1'b1; hold <= 8; end
      end else if (low_cnt > 0) begin
        slave_low <= ~slv_byte[sidx];
        hold      <= 8;
        sidx      <= sidx + 3'd1;
      end else if (hold > 1) begin
        hold <= hold - 1;
      end else begin
        hold <= 0; slave_low <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, act, exp, t);
    end
  endtask

  // t = number of rising edges since reset release
  int t;
  always @(posedge clk or negedge reset)
    if (!reset) t <= 0; else t <= t + 1;

  // Timing with default parameters:
  // edges 1..48 reset low, 49..96 presence window, then eight 18-edge slots
  // (2 low + 16 released). Data is sampled on edge 104+18k. DONE begins at edge 241.
  task automatic model(input int tt, input logic pres, input logic [7:0] b,
                       output logic e_en, output logic e_cycl, output logic e_init,
                       output logic e_rcvd, output logic e_idata,
                       output logic [9:0] e_cnt, output logic [7:0] e_mem);
    int p, s, r;
    e_en = 0; e_cycl = 0; e_init = 0; e_rcvd = 0; e_idata = 0; e_cnt = 0; e_mem = 0;
    if (tt >= 1) begin
      if (!pres || tt <= 96) begin
        p = (tt - 1) % 96;
        e_en  = (p < 48);
        e_cnt = 10'((p < 48) ? p : p - 48);
      end else if (tt <= 240) begin
        s = tt - 97; r = s % 18;
        if (r < 2) begin e_en = 1; e_cycl = 1; e_cnt = 10'(r); end
        else begin e_cnt = 10'(r - 2); e_cycl = (r != 17); end
      end else begin
        e_rcvd = 1;
        e_cnt  = 10'((tt - 241 > 1023) ? 1023 : tt - 241);
      end
      if (pres) begin
        e_init = (tt >= 54);
        for (int k = 0; k < 8; k++)
          if (tt >= 104 + 18 * k) begin e_mem[k] = b[k]; e_idata = b[k]; end
      end
    end
  endtask

  logic chk_on = 1'b0;
  always @(negedge clk) begin
    logic x_en, x_cycl, x_init, x_rcvd, x_idata;
    logic [9:0] x_cnt;
    logic [7:0] x_mem;
    if (chk_on) begin
      if (reset) model(t, slv_present, slv_byte, x_en, x_cycl, x_init, x_rcvd, x_idata, x_cnt, x_mem);
      else model(0, 1'b0, 8'h00, x_en, x_cycl, x_init, x_rcvd, x_idata, x_cnt, x_mem);
      check("en", en, x_en);
      check("cycl", cycl, x_cycl);
      check("cnt", master_cnt, x_cnt);
      check("init", master_init, x_init);
      check("rcvd", rcvd, x_rcvd);
      check("idata", master_idata, x_idata);
      check("mem", master_mem, x_mem);
      if (en) check("port_driven", port, 1'b0);
      else if (!slave_low) check("port_released", port, 1'b1);
    end
  end

  task automatic start(input logic pres, input logic [7:0] b);
    reset = 1'b0;
    slv_present = pres; slv_byte = b;
    @(posedge clk); #2;
    check("rst_en", en, 0);
    check("rst_mem", master_mem, 0);
    check("rst_cnt", master_cnt, 0);
    check("rst_flags", {master_init, cycl, rcvd, master_idata}, 0);
    reset = 1'b1;
  endtask

  task automatic wait_rcvd(input logic [7:0] b);
    int n = 0;
    while (rcvd !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    check("rcvd_in_time", (n < 400), 1);
    repeat (5) @(posedge clk);
    #1;
    check("final_mem", master_mem, b);
    check("final_rcvd", rcvd, 1);
    check("final_en", en, 0);
  endtask

  initial begin
    chk_on = 1'b1;
    // presence + 0xAA, 0x00, 0xFF
    start(1'b1, 8'hAA); wait_rcvd(8'hAA);
    start(1'b1, 8'h00); wait_rcvd(8'h00);
    start(1'b1, 8'hFF); wait_rcvd(8'hFF);

    // no slave: endless 48-low / 48-released retry
    start(1'b0, 8'h00);
    repeat (300) @(posedge clk);
    #1;
    check("noslave_init", master_init, 0);
    check("noslave_rcvd", rcvd, 0);

    // abort during the 4th slot (t=156 is in slot 3's released part)
    start(1'b1, 8'h5C);
    while (t < 156) @(posedge clk);
    #2;
    check("pre_abort_mem", master_mem, 8'h04);
    reset = 1'b0;
    #1;
    check("abort_en", en, 0);
    check("abort_mem", master_mem, 0);
    check("abort_cnt", master_cnt, 0);
    check("abort_flags", {master_init, cycl, rcvd, master_idata}, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    wait_rcvd(8'h5C);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
